// File: rtl/misaligned_access_unit.sv
// misaligned_access_unit: passes aligned loads/stores straight to data_memory and
// splits misaligned halfword/word accesses into sequential byte accesses while stalling the core.
module misaligned_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_type,
    input  logic                  req_unsigned,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_ls_type,
    output logic                  mem_unsigned,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [CNT_WIDTH-1:0]  misaligned_cnt
);
    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic                  r_half;
    logic                  r_unsigned;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_req;
    logic [1:0]            w_type;
    logic                  w_mis;
    logic                  w_start;
    logic                  w_last;
    logic [4:0]            w_shift;
    logic [7:0]            w_byte_in;
    logic [7:0]            w_wbyte;
    logic [DATA_WIDTH-1:0] w_asm;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_req     = req_read | req_write;
    assign w_type    = (req_type == LS_BYTE || req_type == LS_HALF) ? req_type : LS_WORD;
    assign w_mis     = ((w_type == LS_HALF) & req_addr[0]) | ((w_type == LS_WORD) & (|req_addr[1:0]));
    assign w_start   = (r_state == IDLE) & w_req & w_mis;
    assign w_last    = (r_state == SPLIT) & (r_idx == (r_half ? 2'd1 : 2'd3));
    assign w_shift   = {r_idx, 3'b000};
    assign w_byte_in = mem_read_data[7:0];
    assign w_wbyte   = r_wdata[w_shift +: 8];
    // The final byte is still on the memory bus, so merge it live rather than waiting a cycle.
    assign w_asm     = r_buf | ({{(DATA_WIDTH-8){1'b0}}, w_byte_in} << w_shift);
    assign w_ext     = r_half ? {{16{~r_unsigned & w_asm[15]}}, w_asm[15:0]} : w_asm;
    assign misaligned_cnt = r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = w_start ? SPLIT : w_last ? IDLE : r_state;
    end

    // Outputs are gated by rstn so an abandoned split stops driving memory immediately.
    always_comb begin
        stall          = 1'b0;
        rdata          = '0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_ls_type    = LS_BYTE;
        mem_unsigned   = 1'b0;
        if (rstn && r_state == SPLIT) begin
            mem_address    = r_addr + ADDR_WIDTH'(r_idx);
            mem_write_data = {{(DATA_WIDTH-8){1'b0}}, w_wbyte};
            mem_read       = ~r_write;
            mem_write      = r_write;
            mem_unsigned   = 1'b1;
            stall          = ~w_last;
            rdata          = (w_last & ~r_write) ? w_ext : '0;
        end else if (rstn && w_req) begin
            mem_address    = req_addr;
            mem_read       = ~req_write;
            mem_write      = req_write;
            mem_ls_type    = w_mis ? LS_BYTE : w_type;
            mem_unsigned   = w_mis | req_unsigned;
            mem_write_data = w_mis ? {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]} : req_wdata;
            stall          = w_mis;
            rdata          = (w_mis | req_write) ? '0 : mem_read_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx      <= '0;
            r_buf      <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_half     <= 1'b0;
            r_unsigned <= 1'b0;
            r_cnt      <= '0;
        end else if (w_start) begin
            r_idx      <= 2'd1;
            r_buf      <= {{(DATA_WIDTH-8){1'b0}}, w_byte_in};
            r_wdata    <= req_wdata;
            r_addr     <= req_addr;
            r_write    <= req_write;
            r_half     <= (w_type == LS_HALF);
            r_unsigned <= req_unsigned;
        end else if (r_state == SPLIT) begin
            r_buf[w_shift +: 8] <= w_byte_in;
            r_idx               <= r_idx + 2'd1;
            if (w_last && !(&r_cnt))
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_misaligned_access_unit.sv
// tb_misaligned_access_unit: directed tests against a small byte-addressed data_memory model.
module tb_misaligned_access_unit;
    localparam logic [1:0] LB = 2'b00;
    localparam logic [1:0] LH = 2'b01;
    localparam logic [1:0] LW = 2'b10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_type = '0;
    logic        stall, mem_read, mem_write, mem_unsigned;
    logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
    logic [1:0]  mem_ls_type;
    logic [15:0] misaligned_cnt;
    logic        mem_clr = 1'b1;
    logic [7:0]  mem [0:63];
    logic [5:0]  ra;
    logic [7:0]  b0, b1, b2, b3;
    int          checks = 0;
    int          errors = 0;

    misaligned_access_unit dut (
        .clk(clk), .rstn(rstn), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
        .req_unsigned(req_unsigned), .stall(stall), .rdata(rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ls_type(mem_ls_type),
        .mem_unsigned(mem_unsigned), .mem_read_data(mem_read_data),
        .misaligned_cnt(misaligned_cnt)
    );

    always #5 clk = ~clk;

    assign ra = mem_address[5:0];
    assign b0 = mem[ra];
    assign b1 = mem[ra + 6'd1];
    assign b2 = mem[ra + 6'd2];
    assign b3 = mem[ra + 6'd3];

    always_comb begin
        mem_read_data = (mem_ls_type == LB) ? {{24{b0[7] & ~mem_unsigned}}, b0} :
                        (mem_ls_type == LH) ? {{16{b1[7] & ~mem_unsigned}}, b1, b0} :
                                              {b3, b2, b1, b0};
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        end else if (mem_write) begin
            mem[ra] <= mem_write_data[7:0];
            if (mem_ls_type != LB) mem[ra + 6'd1] <= mem_write_data[15:8];
            if (mem_ls_type != LB && mem_ls_type != LH) begin
                mem[ra + 6'd2] <= mem_write_data[23:16];
                mem[ra + 6'd3] <= mem_write_data[31:24];
            end
        end
    end

    task automatic set_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] t, input logic u);
        req_read = rd; req_write = wr; req_addr = a; req_wdata = d; req_type = t; req_unsigned = u;
    endtask

    task automatic idle_req();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, LB, 1'b0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        set_req(1'b0, 1'b1, 32'h1D, 32'hDEADBEEF, LW, 1'b0);
        #2;
        checks++; if (stall !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL reset_ctrl got stall=%b wr=%b rd=%b want 0 0 0", stall, mem_write, mem_read); end
        checks++; if (rdata !== 32'h0 || mem_address !== 32'h0) begin errors++; $display("FAIL reset_data got rdata=%h addr=%h want 0 0", rdata, mem_address); end
        checks++; if (misaligned_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", misaligned_cnt); end
        idle_req();
        step(); step();
        rstn = 1'b1; mem_clr = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL idle got stall=%b rd=%b wr=%b rdata=%h want 0 0 0 0", stall, mem_read, mem_write, rdata); end
        step();
    endtask

    task automatic test_aligned();
        set_req(1'b0, 1'b1, 32'h1C, 32'hF0F0F0F0, LW, 1'b0);
        @(negedge clk);
        checks++; if (stall !== 1'b0 || mem_write !== 1'b1 || mem_address !== 32'h1C || mem_ls_type !== LW || mem_write_data !== 32'hF0F0F0F0) begin errors++; $display("FAIL aligned_store got stall=%b wr=%b addr=%h type=%b wd=%h want 0 1 1c 10 f0f0f0f0", stall, mem_write, mem_address, mem_ls_type, mem_write_data); end
        step();
        set_req(1'b1, 1'b0, 32'h1C, 32'h0, 2'b11, 1'b0);
        @(negedge clk);
        checks++; if (stall !== 1'b0 || mem_ls_type !== LW || rdata !== 32'hF0F0F0F0) begin errors++; $display("FAIL aligned_load got stall=%b type=%b rdata=%h want 0 10 f0f0f0f0", stall, mem_ls_type, rdata); end
        step(); idle_req();
        checks++; if (misaligned_cnt !== 16'd0) begin errors++; $display("FAIL aligned_cnt got %0d want 0", misaligned_cnt); end
    endtask

    task automatic test_mis_word_store();
        logic [31:0] d = 32'h11223344;
        set_req(1'b0, 1'b1, 32'h1D, d, LW, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (mem_address !== 32'h1D + k || mem_write_data[7:0] !== d[8*k +: 8] || mem_write !== 1'b1 || mem_ls_type !== LB || stall !== (k < 3)) begin errors++; $display("FAIL mis_store_%0d got addr=%h byte=%h wr=%b type=%b stall=%b want %h %h 1 00 %b", k, mem_address, mem_write_data[7:0], mem_write, mem_ls_type, stall, 32'h1D + k, d[8*k +: 8], k < 3); end
            step();
        end
        idle_req();
        checks++; if (misaligned_cnt !== 16'd1) begin errors++; $display("FAIL mis_store_cnt got %0d want 1", misaligned_cnt); end
    endtask

    task automatic test_mis_word_load();
        set_req(1'b1, 1'b0, 32'h1D, 32'h0, LW, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (stall !== (k < 3) || mem_read !== 1'b1 || mem_address !== 32'h1D + k) begin errors++; $display("FAIL mis_load_%0d got stall=%b rd=%b addr=%h want %b 1 %h", k, stall, mem_read, mem_address, k < 3, 32'h1D + k); end
            if (k == 3) begin
                checks++; if (rdata !== 32'h11223344) begin errors++; $display("FAIL mis_load_data got %h want 11223344", rdata); end
            end
            step();
        end
        idle_req();
        checks++; if (misaligned_cnt !== 16'd2) begin errors++; $display("FAIL mis_load_cnt got %0d want 2", misaligned_cnt); end
    endtask

    task automatic test_half_load();
        set_req(1'b0, 1'b1, 32'h0B, 32'h34, LB, 1'b0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL byte_store got stall=%b want 0", stall); end
        step();
        set_req(1'b0, 1'b1, 32'h0C, 32'hF2, LB, 1'b0);
        step();
        for (int u = 0; u < 2; u++) begin
            set_req(1'b1, 1'b0, 32'h0B, 32'h0, LH, u[0]);
            @(negedge clk);
            checks++; if (stall !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL half_first_u%0d got stall=%b rdata=%h want 1 0", u, stall, rdata); end
            step();
            @(negedge clk);
            checks++; if (stall !== 1'b0 || rdata !== (u == 1 ? 32'h0000F234 : 32'hFFFFF234)) begin errors++; $display("FAIL half_last_u%0d got stall=%b rdata=%h want 0 %h", u, stall, rdata, u == 1 ? 32'h0000F234 : 32'hFFFFF234); end
            step();
        end
        idle_req();
        checks++; if (misaligned_cnt !== 16'd4) begin errors++; $display("FAIL half_cnt got %0d want 4", misaligned_cnt); end
    endtask

    task automatic test_wrap();
        set_req(1'b0, 1'b1, 32'hFFFFFFFE, 32'hAABBCCDD, LW, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (mem_address !== 32'hFFFFFFFE + k) begin errors++; $display("FAIL wrap_addr_%0d got %h want %h", k, mem_address, 32'hFFFFFFFE + k); end
            step();
        end
        idle_req();
        checks++; if (misaligned_cnt !== 16'd5) begin errors++; $display("FAIL wrap_cnt got %0d want 5", misaligned_cnt); end
    endtask

    task automatic test_reset_mid();
        set_req(1'b0, 1'b1, 32'h21, 32'h55667788, LW, 1'b0);
        step();
        @(negedge clk);
        checks++; if (mem_address !== 32'h22 || stall !== 1'b1) begin errors++; $display("FAIL mid_pre got addr=%h stall=%b want 22 1", mem_address, stall); end
        rstn = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || mem_write !== 1'b0 || misaligned_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset got stall=%b wr=%b cnt=%0d want 0 0 0", stall, mem_write, misaligned_cnt); end
        idle_req();
        step();
        rstn = 1'b1;
        set_req(1'b1, 1'b0, 32'h1C, 32'h0, LW, 1'b0);
        @(negedge clk);
        checks++; if (stall !== 1'b0 || mem_read !== 1'b1 || rdata !== 32'h223344F0) begin errors++; $display("FAIL mid_after got stall=%b rd=%b rdata=%h want 0 1 223344f0", stall, mem_read, rdata); end
        step();
        set_req(1'b1, 1'b0, 32'h21, 32'h0, LB, 1'b1);
        @(negedge clk);
        checks++; if (rdata !== 32'h88) begin errors++; $display("FAIL mid_byte0 got %h want 88", rdata); end
        step();
        set_req(1'b1, 1'b0, 32'h22, 32'h0, LB, 1'b1);
        @(negedge clk);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_byte1 got %h want 0", rdata); end
        step(); idle_req();
        checks++; if (misaligned_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", misaligned_cnt); end
    endtask

    task automatic test_simultaneous();
        set_req(1'b1, 1'b1, 32'h10, 32'h12345678, LW, 1'b0);
        @(negedge clk);
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL simul got wr=%b rd=%b stall=%b rdata=%h want 1 0 0 0", mem_write, mem_read, stall, rdata); end
        step();
        set_req(1'b1, 1'b0, 32'h10, 32'h0, LW, 1'b0);
        @(negedge clk);
        checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL simul_readback got %h want 12345678", rdata); end
        step(); idle_req();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_mis_word_store();
        test_mis_word_load();
        test_half_load();
        test_wrap();
        test_reset_mid();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/misaligned_access_unit.md
Name: misaligned_access_unit

Overview:
- Sits between the core's load/store datapath and data_memory, and drives data_memory's address, write_data, mem_read, mem_write, load_store_type and load_unsigned inputs.
- Naturally aligned accesses pass straight through in one cycle.
- Misaligned halfword and word accesses are split into sequential single-byte data_memory accesses. While a split is in progress, the unit stalls the core and assembles the load result.
- A saturating counter records how many split transactions have occurred.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; fixed at 32, and 4 bytes per word is required
CNT_WIDTH, 16, width of the misaligned-transaction counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rstn  input  1  reset, asynchronous, active-low
req_read  input  1  core load request
req_write  input  1  core store request; if both requests are high, the store wins
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, LSB-justified
req_type  input  2  LS_BYTE / LS_HALF / LS_WORD from controls.sv; any other code is treated as LS_WORD
req_unsigned  input  1  zero-extend load when 1, sign-extend when 0
stall  output  1  core must hold its PC and request while high
rdata  output  DATA_WIDTH  extended load result; valid when stall==0
mem_address  output  ADDR_WIDTH  to data_memory address
mem_write_data  output  DATA_WIDTH  to data_memory write_data
mem_read  output  1  to data_memory
mem_write  output  1  to data_memory
mem_ls_type  output  2  to data_memory load_store_type
mem_unsigned  output  1  to data_memory load_unsigned
mem_read_data  input  DATA_WIDTH  from data_memory read_data; combinational read
misaligned_cnt  output  CNT_WIDTH  count of split transactions

Behaviour:
- The clock and reset are one clock, clk, and one reset, rstn, which is asynchronous and active-low.
- Reset (rstn=0, asynchronous):
  - FSM goes to IDLE.
  - Byte index, assembly buffer, latched request and misaligned_cnt clear to 0.
  - All mem_* outputs are 0, stall=0, rdata=0.
  - Reset in the middle of a split abandons the split. Bytes already written stay in memory; no further bytes are issued.
- Misalignment rules:
  - LS_HALF is misaligned when addr[0]=1.
  - LS_WORD is misaligned when addr[1:0]!=0.
  - LS_BYTE is never misaligned.
- IDLE with no request: mem_read=mem_write=0, stall=0, rdata=0.
- IDLE with an aligned request (pass-through, zero added latency):
  - All mem_* outputs are driven combinationally from req_* inputs.
  - rdata=mem_read_data; stall=0; the FSM stays in IDLE.
- IDLE with a misaligned request: N=2 for halfword, N=4 for word. In the same cycle:
  - Byte 0 is issued: mem_address=req_addr, mem_ls_type=LS_BYTE, mem_unsigned=1.
  - For a store, mem_write_data[7:0]=req_wdata[7:0].
  - stall=1.
  - At the clock edge: latch the request, store mem_read_data[7:0] in buffer byte 0, set idx=1, go to SPLIT.
- SPLIT state, byte k=idx:
  - mem_address=latched_addr+k, modulo 2^ADDR_WIDTH (so addresses wrap at the top of the address space).
  - mem_ls_type=LS_BYTE, mem_unsigned=1.
  - For a store, the write byte is latched_wdata[8k+7:8k].
  - For a load, the byte comes from mem_read_data[7:0] into buffer byte k.
  - stall=1 while k<N-1.
- Final SPLIT cycle (k=N-1):
  - stall=0.
  - rdata = buffer bytes plus the live byte k, then sign- or zero-extended from 16 bits (halfword) or taken as the full 32 bits (word), according to latched_unsigned.
  - At the clock edge: return to IDLE, and increment misaligned_cnt.
- misaligned_cnt saturates at all-ones and does not wrap.
- Total cycles for a misaligned access: 2 (halfword) or 4 (word). The stall-high cycle count is N-1.
- Request inputs are ignored in SPLIT; only latched values are used. The core re-presents the next instruction after stall falls.
- rdata is 0 for stores and for idle cycles.

Test Plan:
- Aligned pass-through: LS_WORD store of 0xF0F0F0F0 to 0x1C, then load from 0x1C. Required: stall stays 0, rdata=0xF0F0F0F0, misaligned_cnt=0.
- Misaligned word store: 0x11223344 to 0x1D. Required: stall high for 3 cycles; mem_address sequence 0x1D,0x1E,0x1F,0x20 with bytes 0x44,0x33,0x22,0x11. A following LS_WORD load from 0x1D returns 0x11223344 after 3 stall cycles; misaligned_cnt=2.
- Misaligned halfword load from 0x0B, with 0x34 at 0x0B and 0xF2 at 0x0C. Required: signed load gives rdata=0xFFFFF234; unsigned load gives 0x0000F234; stall high for exactly 1 cycle each.
- Wrap-around: LS_WORD store to 0xFFFFFFFE. Required: mem_address sequence 0xFFFFFFFE,0xFFFFFFFF,0x00000000,0x00000001.
- Reset mid-split: rstn=0 during the 2nd byte of a misaligned word store. Required: immediately stall=0 and mem_write=0; misaligned_cnt=0; the next aligned request passes through normally.
- Simultaneous requests: req_read=req_write=1 on an aligned word. Required: mem_write=1, mem_read=0.
